// File: rtl/dragon_pkg.sv
// Shared dragon definitions: direction codes, trail FSM states, coordinate widths, spawn point.
// Used by the dragon head, the body trail and the renderer.
package dragon_pkg;

    localparam int COORD_W = 4;
    localparam int LOC_W   = 2 * COORD_W;
    localparam int DIR_W   = 3;
    localparam int LEN_W   = 4;

    localparam logic [LOC_W-1:0] DEFAULT_SPAWN = 8'h00;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 3'd0,
        DIR_RIGHT = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Requested trail length limited to the physical segment capacity.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req,
                                                   input logic [LEN_W-1:0] cap);
        return (req > cap) ? cap : req;
    endfunction

endpackage

// File: rtl/dragon_body_trail_if.sv
// Head-step channel between the dragon head (master) and the body trail (slave).
interface dragon_body_trail_if;
    import dragon_pkg::*;

    // A step transfers on a rising edge where move_valid && move_ready; the master holds all
    // payload fields stable while move_valid is high, and move_ready never depends on move_valid.
    logic             move_valid;
    logic             move_ready;
    logic [LOC_W-1:0] head_location;
    logic [DIR_W-1:0] head_direction;
    logic [LEN_W-1:0] target_length;
    logic [LOC_W-1:0] player_location;

    modport master (
        output move_valid, head_location, head_direction, target_length, player_location,
        input  move_ready
    );

    modport slave (
        input  move_valid, head_location, head_direction, target_length, player_location,
        output move_ready
    );

endinterface

// File: rtl/dragon_seg_scanner.sv
// Step-handshake FSM plus the one-segment-per-cycle collision scan and hit flags.
// Head-vs-segment compare exists only when DRAGON_SELF_HIT_EN is defined.
module dragon_seg_scanner
    import dragon_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             move_valid,
    input  logic [LEN_W-1:0] len_next,
    input  logic [LEN_W-1:0] body_length,
    input  logic [LOC_W-1:0] player_location,
    input  logic [LOC_W-1:0] scan_loc,
`ifdef DRAGON_SELF_HIT_EN
    input  logic [LOC_W-1:0] head_loc,
`endif
    output logic [LEN_W-1:0] scan_idx,
    output state_e           state,
    output logic             ready,
    output logic             scan_done,
    output logic             player_hit,
    output logic             self_hit
);

    state_e           state_next;
    logic [LOC_W-1:0] player_q;
    logic             acc_player;
    logic             acc_self;
    logic             cmp_player;
    logic             cmp_self;
    logic             last_seg;
    logic             accept;

    assign accept     = move_valid && (state == ST_IDLE);
    assign cmp_player = (scan_loc == player_q);
`ifdef DRAGON_SELF_HIT_EN
    assign cmp_self   = (scan_loc == head_loc);
`else
    assign cmp_self   = 1'b0;
`endif
    assign last_seg   = (scan_idx == body_length - LEN_W'(1));

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        scan_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (move_valid) begin
                    // An empty trail has nothing to scan; report cleared flags at once.
                    state_next = (len_next == '0) ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (last_seg) state_next = ST_DONE;
            end
            ST_DONE: begin
                scan_done  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            scan_idx   <= '0;
            player_q   <= '0;
            acc_player <= 1'b0;
            acc_self   <= 1'b0;
            player_hit <= 1'b0;
            self_hit   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                scan_idx   <= '0;
                player_q   <= player_location;
                acc_player <= 1'b0;
                acc_self   <= 1'b0;
                if (len_next == '0) begin
                    player_hit <= 1'b0;
                    self_hit   <= 1'b0;
                end
            end else if (state == ST_SCAN) begin
                scan_idx   <= scan_idx + LEN_W'(1);
                acc_player <= acc_player | cmp_player;
                acc_self   <= acc_self | cmp_self;
                // Flags land on the edge into DONE so they are valid alongside scan_done.
                if (last_seg) begin
                    player_hit <= acc_player | cmp_player;
                    self_hit   <= acc_self | cmp_self;
                end
            end
        end
    end

endmodule

// File: rtl/dragon_body_trail.sv
// Body trail behind the dragon head: segment shift register, length tracking, renderer read port.
// Optional head-vs-body collision is enabled by defining DRAGON_SELF_HIT_EN.
module dragon_body_trail
    import dragon_pkg::*;
#(
    parameter int               MAX_SEGMENTS = 8,
    parameter logic [LOC_W-1:0] SPAWN_LOC    = DEFAULT_SPAWN
) (
    input  logic                frame_clk,
    input  logic                rst_n,
    dragon_body_trail_if.slave  step,
    input  logic [LEN_W-1:0]    seg_rd_index,
    output logic [LOC_W-1:0]    seg_rd_location,
    output logic [DIR_W-1:0]    seg_rd_direction,
    output logic                seg_rd_valid,
    output logic [LEN_W-1:0]    body_length,
    output logic                scan_done,
    output logic                player_hit,
    output logic                self_hit,
    output state_e              state_dbg
);

    logic [LOC_W-1:0] head_loc;
    logic [DIR_W-1:0] head_dir;
    logic [LOC_W-1:0] seg_loc [MAX_SEGMENTS];
    logic [DIR_W-1:0] seg_dir [MAX_SEGMENTS];
    logic [LEN_W-1:0] len_tgt;
    logic [LEN_W-1:0] len_next;
    logic [LEN_W-1:0] scan_idx;
    logic [LOC_W-1:0] scan_loc;
    logic             ready;
    logic             accept;

    assign step.move_ready = ready;
    assign accept          = step.move_valid && ready;

    // Length moves at most one step toward the clamped target per accepted move.
    always_comb begin
        len_tgt  = clamp_len(step.target_length, LEN_W'(MAX_SEGMENTS));
        len_next = body_length;
        if (body_length < len_tgt) begin
            len_next = body_length + LEN_W'(1);
        end else if (body_length > len_tgt) begin
            len_next = body_length - LEN_W'(1);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!rst_n) begin
            head_loc    <= SPAWN_LOC;
            head_dir    <= '0;
            body_length <= '0;
            for (int i = 0; i < MAX_SEGMENTS; i++) begin
                seg_loc[i] <= SPAWN_LOC;
                seg_dir[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 1; i < MAX_SEGMENTS; i++) begin
                seg_loc[i] <= seg_loc[i-1];
                seg_dir[i] <= seg_dir[i-1];
            end
            seg_loc[0]  <= head_loc;
            seg_dir[0]  <= head_dir;
            head_loc    <= step.head_location;
            head_dir    <= step.head_direction;
            body_length <= len_next;
        end
    end

    // Explicit mux keeps out-of-range indices (up to 15) away from the array.
    always_comb begin
        seg_rd_location  = '0;
        seg_rd_direction = '0;
        scan_loc         = '0;
        seg_rd_valid     = (seg_rd_index < body_length);
        for (int i = 0; i < MAX_SEGMENTS; i++) begin
            if (seg_rd_valid && (seg_rd_index == LEN_W'(i))) begin
                seg_rd_location  = seg_loc[i];
                seg_rd_direction = seg_dir[i];
            end
            if (scan_idx == LEN_W'(i)) begin
                scan_loc = seg_loc[i];
            end
        end
    end

    dragon_seg_scanner u_scanner (
        .clk             (frame_clk),
        .rst_n           (rst_n),
        .move_valid      (step.move_valid),
        .len_next        (len_next),
        .body_length     (body_length),
        .player_location (step.player_location),
        .scan_loc        (scan_loc),
`ifdef DRAGON_SELF_HIT_EN
        .head_loc        (head_loc),
`endif
        .scan_idx        (scan_idx),
        .state           (state_dbg),
        .ready           (ready),
        .scan_done       (scan_done),
        .player_hit      (player_hit),
        .self_hit        (self_hit)
    );

endmodule
